// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP adder datapath: field widths,
// packed word layout, normalizer states and the field packing helper.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  function automatic fp32_t pack_fp(input logic             sign,
                                    input logic [EXP_W-1:0] exponent,
                                    input logic [MAN_W-1:0] mantissa);
    fp32_t word;
    word.sign     = sign;
    word.exponent = exponent;
    word.mantissa = mantissa;
    return word;
  endfunction

endpackage

// File: rtl/fp_normalize_pack.sv
// FP adder back end: normalizes the aligned mantissa sum one left shift per
// cycle, then packs sign/exponent/mantissa into a single-precision word.
module fp_normalize_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic             signIn,
  input  logic [EXP_W-1:0] exponentIn,
  input  logic [MAN_W+1:0] sumMantissa,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      Result,
  output logic             overflow,
  output logic             underflow
);

  import fp_pkg::*;

  // One spare exponent bit keeps the +1/-1 steps free of wrap-around.
  localparam logic [EXP_W:0] EXP_TOP    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_TOP_M1 = {1'b0, {(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W:0] EXP_ONE    = {{EXP_W{1'b0}}, 1'b1};

  norm_state_t      state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [MAN_W+1:0] sum_q, sum_d;
  fp32_t            result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             outValid_q, outValid_d;

  assign inReady   = (state_q == IDLE) && !reset;
  assign outValid  = outValid_q;
  assign Result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      outValid_q  <= outValid_d;
    end
  end

  // NORM rules are ordered: special exponent, zero, carry, normalized, denormal, shift.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sum_d       = sum_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    outValid_d  = outValid_q;

    unique case (state_q)
      IDLE: begin
        if (inValid && inReady) begin
          sign_d  = signIn;
          exp_d   = {1'b0, exponentIn};
          sum_d   = sumMantissa;
          state_d = NORM;
        end
      end

      NORM: begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (exp_q == EXP_TOP) begin
          result_d = pack_fp(sign_q, '1, sum_q[MAN_W-1:0]);
          state_d  = DONE;
        end else if (sum_q == '0) begin
          result_d = pack_fp(sign_q, '0, '0);
          state_d  = DONE;
        end else if (sum_q[MAN_W+1]) begin
          if (exp_q == EXP_TOP_M1) begin
            result_d   = pack_fp(sign_q, '1, '0);
            overflow_d = 1'b1;
          end else begin
            result_d = pack_fp(sign_q, exp_q[EXP_W-1:0] + 1'b1, sum_q[MAN_W:1]);
          end
          state_d = DONE;
        end else if (sum_q[MAN_W]) begin
          result_d = pack_fp(sign_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]);
          state_d  = DONE;
        end else if (exp_q <= EXP_ONE) begin
          result_d    = pack_fp(sign_q, '0, sum_q[MAN_W-1:0]);
          underflow_d = 1'b1;
          state_d     = DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 1'b1;
        end
      end

      DONE: begin
        // outValid rises one cycle after entering DONE, then waits for the consumer.
        if (outValid_q && outReady) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          outValid_d = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        outValid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed table-driven bench for fp_normalize_pack, plus backpressure and
// mid-operation reset sequences.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic        signIn;
  logic [7:0]  exponentIn;
  logic [24:0] sumMantissa;
  logic        outValid;
  logic        outReady;
  logic [31:0] Result;
  logic        overflow;
  logic        underflow;

  int nApplied    = 0;
  int nMiscompare = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] sum;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fp_normalize_pack dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .signIn     (signIn),
    .exponentIn (exponentIn),
    .sumMantissa(sumMantissa),
    .outValid   (outValid),
    .outReady   (outReady),
    .Result     (Result),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard = 0;
    @(negedge clk);
    signIn      = v.sign;
    exponentIn  = v.exp;
    sumMantissa = v.sum;
    inValid     = 1'b1;
    while (!inReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    compare("acceptReady", {31'b0, inReady}, 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    int   lat      = 0;
    logic sawReady = 1'b0;
    while (!outValid && lat < 40) begin
      if (inReady) sawReady = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    compare({tag, " latency"},   lat, v.lat);
    compare({tag, " result"},    Result, v.result);
    compare({tag, " overflow"},  {31'b0, overflow}, {31'b0, v.ovf});
    compare({tag, " underflow"}, {31'b0, underflow}, {31'b0, v.unf});
    compare({tag, " busyReady"}, {31'b0, sawReady}, 32'd0);
  endtask

  initial begin
    //          sign  exp    sum           result         ovf   unf   lat
    vecs[0]  = '{1'b0, 8'h80, 25'h0800000, 32'h40000000, 1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 2};
    vecs[2]  = '{1'b0, 8'h90, 25'h0000400, 32'h41800000, 1'b0, 1'b0, 15};
    vecs[3]  = '{1'b1, 8'h80, 25'h0000000, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 2};
    vecs[5]  = '{1'b0, 8'h05, 25'h0000400, 32'h00004000, 1'b0, 1'b1, 6};
    vecs[6]  = '{1'b1, 8'hFF, 25'h0123456, 32'hFF923456, 1'b0, 1'b0, 2};
    vecs[7]  = '{1'b0, 8'h00, 25'h0400000, 32'h00400000, 1'b0, 1'b1, 2};
    vecs[8]  = '{1'b1, 8'h81, 25'h1800001, 32'hC1400000, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b0, 8'h7F, 25'h0600000, 32'h3F400000, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 8'h80, 25'h0000001, 32'h34800000, 1'b0, 1'b0, 25};
    vecs[11] = '{1'b0, 8'h02, 25'h0400000, 32'h00800000, 1'b0, 1'b0, 3};

    reset       = 1'b1;
    inValid     = 1'b0;
    signIn      = 1'b0;
    exponentIn  = '0;
    sumMantissa = '0;
    outReady    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    compare("reset outValid",  {31'b0, outValid}, 32'd0);
    compare("reset Result",    Result, 32'h0);
    compare("reset inReady",   {31'b0, inReady}, 32'd0);
    compare("reset overflow",  {31'b0, overflow}, 32'd0);
    compare("reset underflow", {31'b0, underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare("idle inReady", {31'b0, inReady}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result must hold while the consumer stalls.
    applyStimulus(vecs[0]);
    outReady = 1'b0;
    checkOutput("stall", vecs[0]);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      compare($sformatf("stall%0d outValid", k), {31'b0, outValid}, 32'd1);
      compare($sformatf("stall%0d Result", k), Result, 32'h40000000);
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    compare("release outValid", {31'b0, outValid}, 32'd0);
    compare("release inReady",  {31'b0, inReady}, 32'd1);

    // Reset in the middle of a long normalization, with a new operand offered.
    applyStimulus(vecs[2]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset       = 1'b1;
    signIn      = vecs[9].sign;
    exponentIn  = vecs[9].exp;
    sumMantissa = vecs[9].sum;
    inValid     = 1'b1;
    @(posedge clk);
    #1;
    compare("midReset outValid",  {31'b0, outValid}, 32'd0);
    compare("midReset Result",    Result, 32'h0);
    compare("midReset inReady",   {31'b0, inReady}, 32'd0);
    compare("midReset underflow", {31'b0, underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare("postReset inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("postReset", vecs[9]);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
